// File: rtl/sum4_pkg.sv
// Shared types and constants for the sum4_accum window accumulator.
package sum4_pkg;

    localparam int SUM_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/sum4_acc_add.sv
// ACC_W-bit accumulate adder with carry-out.
// Define SUM4_ACCUM_SAT_EN to saturate on carry instead of wrapping.
module sum4_acc_add #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[ACC_W];

`ifdef SUM4_ACCUM_SAT_EN
    assign sum = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum4_accum.sv
// Accumulates NUM_SAMPLES 4-bit sums per window, presents total with overflow.
// Optional macro SUM4_ACCUM_SAT_EN selects saturating instead of wrapping adds.
module sum4_accum
    import sum4_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int ACC_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam logic [7:0] LAST = 8'(NUM_SAMPLES - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf;
    logic [ACC_W-1:0] add_res;
    logic             add_carry;
    logic [ACC_W-1:0] in_ext;

    assign in_ext = ACC_W'(in_sum);

    sum4_acc_add #(.ACC_W(ACC_W)) u_add (
        .a     (acc),
        .b     (in_ext),
        .sum   (add_res),
        .carry (add_carry)
    );

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_acc   = out_valid ? acc : '0;
    assign out_ovf   = out_valid & ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= in_ext;
                        cnt   <= 8'd1;
                        ovf   <= 1'b0;
                        state <= (NUM_SAMPLES == 1) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc <= add_res;
                        cnt <= cnt + 8'd1;
                        ovf <= ovf | add_carry;
                        if (cnt == LAST) state <= HOLD;
                    end
                end
                HOLD: begin
                    // Result stays frozen until the consumer takes it
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum4_accum.sv
// Directed bench for sum4_accum in three parameterisations.
module tb_sum4_accum;

    typedef struct {
        logic       iv;
        logic [3:0] s;
        logic       ordy;
        logic       clr;
        logic       eir;
        logic       eov;
        logic [7:0] eacc;
        logic       eovf;
    } vec_t;

    logic clk;
    logic rst_n;

    logic       a_clear, a_iv, a_ir, a_ov, a_or, a_ovf;
    logic [3:0] a_is;
    logic [7:0] a_acc;

    logic       b_clear, b_iv, b_ir, b_ov, b_or, b_ovf;
    logic [3:0] b_is;
    logic [4:0] b_acc;

    logic       c_clear, c_iv, c_ir, c_ov, c_or, c_ovf;
    logic [3:0] c_is;
    logic [7:0] c_acc;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    sum4_accum #(.NUM_SAMPLES(4), .ACC_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear),
        .in_valid(a_iv), .in_sum(a_is), .in_ready(a_ir),
        .out_valid(a_ov), .out_ready(a_or),
        .out_acc(a_acc), .out_ovf(a_ovf)
    );

    sum4_accum #(.NUM_SAMPLES(3), .ACC_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .in_valid(b_iv), .in_sum(b_is), .in_ready(b_ir),
        .out_valid(b_ov), .out_ready(b_or),
        .out_acc(b_acc), .out_ovf(b_ovf)
    );

    sum4_accum #(.NUM_SAMPLES(1), .ACC_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(c_clear),
        .in_valid(c_iv), .in_sum(c_is), .in_ready(c_ir),
        .out_valid(c_ov), .out_ready(c_or),
        .out_acc(c_acc), .out_ovf(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic row(input logic iv, input logic [3:0] s,
                       input logic ordy, input logic clr,
                       input logic eir, input logic eov,
                       input logic [7:0] eacc, input logic eovf);
        vec_t v;
        v.iv = iv; v.s = s; v.ordy = ordy; v.clr = clr;
        v.eir = eir; v.eov = eov; v.eacc = eacc; v.eovf = eovf;
        tbl.push_back(v);
    endtask

    initial begin
        int b_exp;
        rst_n = 1'b0;
        a_clear = 0; a_iv = 0; a_is = 0; a_or = 0;
        b_clear = 0; b_iv = 0; b_is = 0; b_or = 0;
        c_clear = 0; c_iv = 0; c_is = 0; c_or = 0;

        // window 1,2,3,4 with immediate transfer
        row(1, 1, 1, 0, 1, 0, 0, 0);
        row(1, 2, 1, 0, 1, 0, 0, 0);
        row(1, 3, 1, 0, 1, 0, 0, 0);
        row(1, 4, 1, 0, 1, 0, 0, 0);
        row(0, 0, 1, 0, 0, 1, 10, 0);
        row(0, 0, 1, 0, 1, 0, 0, 0);
        // back-pressure for 5 cycles, inputs ignored in HOLD
        for (int i = 0; i < 4; i++) row(1, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) row(1, 9, 0, 0, 0, 1, 4, 0);
        row(1, 9, 1, 0, 0, 1, 4, 0);
        row(0, 0, 1, 0, 1, 0, 0, 0);
        // 7,7 then clear with a same-cycle input
        row(1, 7, 1, 0, 1, 0, 0, 0);
        row(1, 7, 1, 0, 1, 0, 0, 0);
        row(1, 5, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) row(1, 1, 1, 0, 1, 0, 0, 0);
        row(0, 0, 1, 0, 0, 1, 4, 0);
        row(0, 0, 1, 0, 1, 0, 0, 0);
        // zero sums still count
        row(1, 0, 1, 0, 1, 0, 0, 0);
        row(1, 0, 1, 0, 1, 0, 0, 0);
        row(1, 0, 1, 0, 1, 0, 0, 0);
        row(1, 15, 1, 0, 1, 0, 0, 0);
        row(0, 0, 1, 0, 0, 1, 15, 0);
        row(0, 0, 1, 0, 1, 0, 0, 0);
        // clear while holding a result
        for (int i = 0; i < 4; i++) row(1, 1, 0, 0, 1, 0, 0, 0);
        row(0, 0, 0, 1, 0, 1, 4, 0);
        row(0, 0, 0, 0, 1, 0, 0, 0);

        #1;
        chk("rst_in_ready", int'(a_ir), 1);
        chk("rst_out_valid", int'(a_ov), 0);
        chk("rst_out_acc", int'(a_acc), 0);
        chk("rst_out_ovf", int'(a_ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            a_iv = tbl[i].iv; a_is = tbl[i].s;
            a_or = tbl[i].ordy; a_clear = tbl[i].clr;
            #1;
            chk($sformatf("v%0d_in_ready", i), int'(a_ir), int'(tbl[i].eir));
            chk($sformatf("v%0d_out_valid", i), int'(a_ov), int'(tbl[i].eov));
            chk($sformatf("v%0d_out_acc", i), int'(a_acc), int'(tbl[i].eacc));
            chk($sformatf("v%0d_out_ovf", i), int'(a_ovf), int'(tbl[i].eovf));
        end

        // async reset while holding 10
        a_clear = 0; a_or = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            a_iv = 1; a_is = 4'(k);
        end
        @(negedge clk);
        a_iv = 0;
        #1;
        chk("hold_acc10", int'(a_acc), 10);
        chk("hold_valid", int'(a_ov), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(a_ov), 0);
        chk("arst_out_acc", int'(a_acc), 0);
        chk("arst_out_ovf", int'(a_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", int'(a_ir), 1);

        // ACC_W=5, NUM_SAMPLES=3 overflow
`ifdef SUM4_ACCUM_SAT_EN
        b_exp = 31;
`else
        b_exp = 13;
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b_iv = 1; b_is = 4'd15;
        end
        @(negedge clk);
        b_iv = 0; b_or = 1;
        #1;
        chk("b_out_valid", int'(b_ov), 1);
        chk("b_out_acc", int'(b_acc), b_exp);
        chk("b_out_ovf", int'(b_ovf), 1);
        @(negedge clk);
        #1;
        chk("b_after_valid", int'(b_ov), 0);
        chk("b_after_ovf", int'(b_ovf), 0);

        // NUM_SAMPLES=1 back-to-back
        @(negedge clk);
        c_iv = 1; c_is = 4'd9; c_or = 1;
        #1;
        chk("c_ready0", int'(c_ir), 1);
        @(negedge clk);
        c_is = 4'd5;
        #1;
        chk("c_hold9_ready", int'(c_ir), 0);
        chk("c_hold9_valid", int'(c_ov), 1);
        chk("c_hold9_acc", int'(c_acc), 9);
        @(negedge clk);
        #1;
        chk("c_idle_ready", int'(c_ir), 1);
        chk("c_idle_valid", int'(c_ov), 0);
        @(negedge clk);
        c_iv = 0;
        #1;
        chk("c_hold5_valid", int'(c_ov), 1);
        chk("c_hold5_acc", int'(c_acc), 5);
        @(negedge clk);
        #1;
        chk("c_end_valid", int'(c_ov), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
